// File: rtl/rs232_pkg.sv
// Shared types for the RS232 receiver: FSM states, per-word status flags,
// default timing constants and the 3-sample majority vote.
package rs232_pkg;

   localparam int BAUD_DIV_DEFAULT   = 27;
   localparam int OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // A FIFO word is {rx_flags_t, data}; data width is a per-instance parameter,
   // so it is appended by the users of this struct rather than held inside it.
   typedef struct packed {
      logic brk;
      logic framing_err;
      logic parity_err;
   } rx_flags_t;

   localparam int RX_FLAG_BITS = $bits(rx_flags_t);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs232_rx_core_if.sv
// Consumer-side bundle of the RS232 receiver: show-ahead head word, handshake
// and FIFO status.
interface rs232_rx_core_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7
);
   logic                  rx_ready;
   logic                  clear_overrun;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_parity_err;
   logic                  rx_framing_err;
   logic                  rx_break;
   logic [ADDR_WIDTH:0]   fifo_used;
   logic                  overrun;

   modport master (
      input  rx_ready, clear_overrun,
      output rx_valid, rx_data, rx_parity_err, rx_framing_err, rx_break,
             fifo_used, overrun
   );

   modport slave (
      output rx_ready, clear_overrun,
      input  rx_valid, rx_data, rx_parity_err, rx_framing_err, rx_break,
             fifo_used, overrun
   );
endinterface

// File: rtl/rs232_rx_fifo.sv
// Show-ahead synchronous FIFO; read data is the current head, a pop advances it.
// Pointers carry one extra bit so used = wr_ptr - rd_ptr spans 0..DEPTH.
module rs232_rx_fifo #(
   parameter int WIDTH      = 11,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   used
);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                do_wr;
   logic                do_rd;

   assign used    = wr_ptr - rd_ptr;
   assign empty   = (used == '0);
   assign full    = (used == (ADDR_WIDTH+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   // A pop frees the head slot in the same edge, so a full FIFO still accepts.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rs232_rx_core.sv
// RS232 receiver: synchroniser, oversampled bit FSM with majority voting, and
// a show-ahead receive FIFO with sticky overrun.
//
//   state     | meaning
//   ST_IDLE   | line idle, tick counters held at 0, waiting for a falling edge
//   ST_START  | start bit; majority 1 is a false start
//   ST_DATA   | DATA_WIDTH data bits, LSB first
//   ST_PARITY | parity bit (only when PARITY_EN)
//   ST_STOP   | STOP_BITS stop bits; word written after the last majority
module rs232_rx_core
   import rs232_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 128,
   parameter int ADDR_WIDTH = 7
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            serial_data_in,
   rs232_rx_core_if.master rx_if
);

   localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int PHW = $clog2(OVERSAMPLE);
   localparam int BIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int WW  = DATA_WIDTH + RX_FLAG_BITS;

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [PHW-1:0] PH_S0     = PHW'(OVERSAMPLE/2 - 1);
   localparam logic [PHW-1:0] PH_S2     = PHW'(OVERSAMPLE/2 + 1);
   localparam logic [PHW-1:0] PH_LAST   = PHW'(OVERSAMPLE - 1);
   localparam logic [BIW-1:0] BIT_LAST  = BIW'(DATA_WIDTH - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic           PAR_ODD   = (PARITY_ODD != 0);

   logic                  rxd_meta, rxd_s, rxd_d;
   rx_state_e             state;
   logic [BCW-1:0]        baud_cnt;
   logic [PHW-1:0]        phase;
   logic [BIW-1:0]        bit_idx;
   logic                  stop_idx;
   logic [1:0]            samp;
   logic                  bit_val;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  parity_bit;
   logic                  ferr;
   logic                  wr_en;
   logic [WW-1:0]         wr_word;

   logic                  tick;
   logic                  maj_now;
   logic                  ferr_final;
   logic                  perr_calc;
   logic                  brk_calc;

   assign tick       = (state != ST_IDLE) && (baud_cnt == BAUD_LAST);
   assign maj_now    = maj3(samp[1], samp[0], rxd_s);
   assign ferr_final = ferr | ~maj_now;
   assign perr_calc  = (PARITY_EN != 0) ? ((^{shreg, parity_bit}) != PAR_ODD) : 1'b0;
   assign brk_calc   = (shreg == '0) && ((PARITY_EN == 0) || !parity_bit) && ferr_final;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta   <= 1'b1;
         rxd_s      <= 1'b1;
         rxd_d      <= 1'b1;
         state      <= ST_IDLE;
         baud_cnt   <= '0;
         phase      <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         samp       <= '0;
         bit_val    <= 1'b0;
         shreg      <= '0;
         parity_bit <= 1'b0;
         ferr       <= 1'b0;
         wr_en      <= 1'b0;
         wr_word    <= '0;
      end else begin
         rxd_meta <= serial_data_in;
         rxd_s    <= rxd_meta;
         rxd_d    <= rxd_s;
         wr_en    <= 1'b0;
         if (state == ST_IDLE) begin
            baud_cnt <= '0;
            phase    <= '0;
            if (rxd_d && !rxd_s) begin
               state <= ST_START;
               samp  <= '0;
            end
         end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (tick) begin
               phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
               if (phase >= PH_S0 && phase <= PH_S2) samp <= {samp[0], rxd_s};
               if (phase == PH_S2) begin
                  bit_val <= maj_now;
                  // The word goes out mid stop bit so a back-to-back start edge is not missed.
                  if (state == ST_STOP) begin
                     ferr <= ferr_final;
                     if (stop_idx == STOP_LAST) begin
                        wr_en   <= 1'b1;
                        wr_word <= {brk_calc, ferr_final, perr_calc, shreg};
                        state   <= ST_IDLE;
                     end
                  end
               end
               if (phase == PH_LAST) begin
                  case (state)
                     ST_START: begin
                        state   <= bit_val ? ST_IDLE : ST_DATA;
                        bit_idx <= '0;
                     end
                     ST_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                           state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                           stop_idx <= 1'b0;
                           ferr     <= 1'b0;
                        end
                     end
                     ST_PARITY: begin
                        parity_bit <= bit_val;
                        state      <= ST_STOP;
                        stop_idx   <= 1'b0;
                        ferr       <= 1'b0;
                     end
                     ST_STOP:  stop_idx <= 1'b1;
                     default:  state    <= ST_IDLE;
                  endcase
               end
            end
         end
      end
   end

   logic          fifo_full;
   logic          fifo_empty;
   logic [WW-1:0] fifo_head;
   logic          pop;
   logic          drop;
   logic          overrun_q;
   rx_flags_t     head_flags;

   assign pop  = !fifo_empty && rx_if.rx_ready;
   assign drop = wr_en && fifo_full && !pop;

   rs232_rx_fifo #(
      .WIDTH      (WW),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_data (wr_word),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .used    (rx_if.fifo_used)
   );

   // A drop in the same cycle as a clear wins, so no lost frame goes unreported.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 overrun_q <= 1'b0;
      else if (drop)                overrun_q <= 1'b1;
      else if (rx_if.clear_overrun) overrun_q <= 1'b0;
   end

   assign {head_flags, rx_if.rx_data} = fifo_head;
   assign rx_if.rx_valid       = !fifo_empty;
   assign rx_if.rx_break       = head_flags.brk;
   assign rx_if.rx_framing_err = head_flags.framing_err;
   assign rx_if.rx_parity_err  = head_flags.parity_err;
   assign rx_if.overrun        = overrun_q;

endmodule
